// File: rtl/cla_pkg.sv
// Shared sizing helpers, legality checks and the lookahead carry function
// used by both the group CLA and the per-stage second-level lookahead.
package cla_pkg;

  localparam int LA_MAX = 32;

  function automatic int ngrp(input int width, input int group);
    return width / group;
  endfunction

  function automatic int slice_w(input int width, input int group, input int stages);
    return (width / group / stages) * group;
  endfunction

  function automatic bit params_ok(input int width, input int group, input int stages);
    if (group < 1 || group > LA_MAX || width < group) return 1'b0;
    if (width % group != 0) return 1'b0;
    if (stages < 1 || stages > width / group) return 1'b0;
    if ((width / group) % stages != 0) return 1'b0;
    return (width / group / stages) <= LA_MAX;
  endfunction

  // Carry out of the low n positions: g[n-1] | p[n-1]g[n-2] | ... | p[n-1:0]ci.
  function automatic logic la_carry(input logic [LA_MAX-1:0] g, input logic [LA_MAX-1:0] p,
                                    input int n, input logic ci);
    logic acc, pp;
    acc = 1'b0;
    pp  = 1'b1;
    for (int j = n - 1; j >= 0; j--) begin
      acc = acc | (pp & g[j]);
      pp  = pp & p[j];
    end
    return acc | (pp & ci);
  endfunction

endpackage

// File: rtl/cla_pipe_adder_group.sv
// Combinational GROUP-bit carry-lookahead block with group generate/propagate
// and the carry into its MSB (needed for signed overflow).
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] x,
  input  logic [GROUP-1:0] y,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             gp_g,
  output logic             gp_p,
  output logic             c_msb
);

  logic [GROUP-1:0] g, p, c;

  always_comb begin
    g = x & y;
    p = x ^ y;
    for (int i = 0; i < GROUP; i++) c[i] = la_carry(32'(g), 32'(p), i, ci);
    s     = p ^ c;
    gp_g  = la_carry(32'(g), 32'(p), GROUP, 1'b0);
    gp_p  = &p;
    c_msb = c[GROUP-1];
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: each stage resolves one slice of groups and
// carries the untouched upper operand bits forward; valid/ready on both sides.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NGRP = ngrp(WIDTH, GROUP);
  localparam int NG   = NGRP / STAGES;
  localparam int SW   = slice_w(WIDTH, GROUP, STAGES);

  if (!params_ok(WIDTH, GROUP, STAGES)) begin : g_bad_params
    $error("cla_pipe_adder: illegal WIDTH/GROUP/STAGES combination");
  end

  // Index k is the input of stage k; index STAGES is the output register.
  logic [STAGES:0]             vin;
  logic [STAGES:0]             adv;
  logic [STAGES:0][WIDTH-1:0]  dat;  // lower slices hold sum, upper still hold a
  logic [STAGES-1:0][WIDTH-1:0] bop;
  logic [STAGES-1:0]           cy;

  assign vin[0]      = in_valid;
  assign dat[0]      = a;
  assign bop[0]      = b ^ {WIDTH{sub}};
  assign cy[0]       = cin ^ sub;
  assign adv[STAGES] = out_ready;
  assign in_ready    = adv[0] & ~sys_rst;
  assign out_valid   = vin[STAGES];
  assign sum         = dat[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [NG-1:0]    gg, gpp, gci, gcm;
    logic [SW-1:0]    s_slc;
    logic             co, ld;
    logic             v_d, v_q;
    logic [WIDTH-1:0] dat_d, dat_q;

    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .x    (dat[k][k*SW + j*GROUP +: GROUP]),
        .y    (bop[k][k*SW + j*GROUP +: GROUP]),
        .ci   (gci[j]),
        .s    (s_slc[j*GROUP +: GROUP]),
        .gp_g (gg[j]),
        .gp_p (gpp[j]),
        .c_msb(gcm[j])
      );
    end

    assign adv[k]   = ~vin[k+1] | adv[k+1];
    assign ld       = adv[k] & vin[k];
    assign vin[k+1] = v_q;
    assign dat[k+1] = dat_q;

    always_comb begin
      for (int j = 0; j < NG; j++) gci[j] = la_carry(32'(gg), 32'(gpp), j, cy[k]);
      co    = la_carry(32'(gg), 32'(gpp), NG, cy[k]);
      v_d   = adv[k] ? vin[k] : v_q;
      dat_d = dat_q;
      if (ld) begin
        dat_d = dat[k];
        dat_d[k*SW +: SW] = s_slc;
      end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        v_q   <= 1'b0;
        dat_q <= '0;
      end else begin
        v_q   <= v_d;
        dat_q <= dat_d;
      end
    end

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] bop_d, bop_q;
      logic             cy_d, cy_q;

      always_comb begin
        bop_d = ld ? bop[k] : bop_q;
        cy_d  = ld ? co : cy_q;
      end

      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
          bop_q <= '0;
          cy_q  <= 1'b0;
        end else begin
          bop_q <= bop_d;
          cy_q  <= cy_d;
        end
      end

      assign bop[k+1] = bop_q;
      assign cy[k+1]  = cy_q;
    end else begin : g_last
      logic cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q;

      always_comb begin
        cout_d = ld ? co : cout_q;
        ovf_d  = ld ? (gcm[NG-1] ^ co) : ovf_q;
        zero_d = ld ? (dat_d == '0) : zero_q;
      end

      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else begin
          cout_q <= cout_d;
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end

      assign cout = cout_q;
      assign ovf  = ovf_q;
      assign zero = zero_q;
    end
  end

endmodule
